// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: FSM states and the register
// control codes that shift_seq_ctrl issues to shift_core.
package shift_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_LOAD  = 2'b01;
    localparam logic [1:0] SR_SHIFT = 2'b10;

endpackage

// File: rtl/shift_core.sv
// Shift register datapath: hold, parallel load, or right shift with a fill
// bit entering at the MSB.
module shift_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctrl,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        case (ctrl)
            SR_LOAD:  q_d = data_in;
            SR_SHIFT: q_d = {shift_in, q_q[WIDTH-1:1]};
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame controller: accepts a parallel word, streams it LSB first under a
// ready/valid handshake, then pulses done for one cycle.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             fill_bit,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [1:0]       sr_ctrl
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sr_q;
    logic             sr_unused;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_ctrl   = SR_HOLD;
        in_ready  = 1'b0;
        ser_valid = (state_q == ST_SHIFT);
        done      = (state_q == ST_DONE);

        // abort overrides everything; rst gating keeps LOAD off while reset is held
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready = !rst;
                    if (in_valid && !rst) begin
                        sr_ctrl = SR_LOAD;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        sr_ctrl = SR_SHIFT;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    shift_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (sr_ctrl),
        .data_in  (in_data),
        .shift_in (fill_bit),
        .q        (sr_q)
    );

    assign ser_out   = sr_q[0];
    assign busy      = (state_q != ST_IDLE);
    assign sr_unused = ^sr_q[WIDTH-1:1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: queue-based frame model compared
// every cycle, plus directed literal scenarios and randomized traffic.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         fill_bit = 1'b0;
    logic         ser_ready = 1'b0;
    logic         abort = 1'b0;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         done;
    logic [1:0]   sr_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fill_bit  (fill_bit),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .sr_ctrl   (sr_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a queue of bits still to be delivered, LSB first.
    bit           m_active = 1'b0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_reg = '0;
    bit           m_bits[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_reg    = '0;
            m_bits.delete();
        end else if (abort) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_bits.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_active) begin
            if (ser_ready) begin
                void'(m_bits.pop_front());
                m_reg = (m_reg >> 1) | (W'(fill_bit) << (W - 1));
                if (m_bits.size() == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (in_valid) begin
            m_reg = in_data;
            for (int i = 0; i < W; i++) m_bits.push_back(in_data[i]);
            m_active = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e_sr;
        if (rst || abort)               e_sr = SR_HOLD;
        else if (m_active)              e_sr = ser_ready ? SR_SHIFT : SR_HOLD;
        else if (!m_done && in_valid)   e_sr = SR_LOAD;
        else                            e_sr = SR_HOLD;
        chk("busy", busy, m_active || m_done);
        chk("ser_valid", ser_valid, m_active);
        chk("done", done, m_done);
        chk("in_ready", in_ready, !rst && !abort && !m_active && !m_done);
        chk("sr_ctrl", sr_ctrl, e_sr);
        chk("ser_out", ser_out, m_active ? m_bits[0] : m_reg[0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit exp_3c[11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        ser_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_sr_ctrl", sr_ctrl, SR_HOLD);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_reg", dut.sr_q, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 chk("post_rst_ready", in_ready, 1);

        // 8'hA5 with sink always ready
        tick();
        in_data = 8'hA5; in_valid = 1'b1;
        #1 chk("a5_accept_sr", sr_ctrl, SR_LOAD);
        for (int c = 1; c <= 8; c++) begin
            tick();
            in_valid = 1'b0;
            chk("a5_bit", ser_out, exp_a5[c-1]);
            chk("a5_valid", ser_valid, 1);
        end
        tick();
        chk("a5_done", done, 1);
        chk("a5_done_ready", in_ready, 0);
        tick();
        chk("a5_done_once", done, 0);
        chk("a5_next_ready", in_ready, 1);

        // 8'h3C with a 3-cycle stall on the third bit
        in_data = 8'h3C; in_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            in_valid = 1'b0;
            ser_ready = !(c >= 3 && c <= 5);
            #1;
            if (c <= 11) chk("3c_bit", ser_out, exp_3c[c-1]);
            if (c >= 3 && c <= 5) chk("3c_stall_sr", sr_ctrl, SR_HOLD);
            if (c == 9) chk("3c_no_early_done", done, 0);
            if (c == 12) chk("3c_done", done, 1);
        end
        ser_ready = 1'b1;
        tick();

        // 8'hFF aborted after four bits
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        #1 chk("ab_sr_hold", sr_ctrl, SR_HOLD);
        chk("ab_no_ready", in_ready, 0);
        tick();
        abort = 1'b0;
        #1 chk("ab_idle", busy, 0);
        chk("ab_no_done", done, 0);
        chk("ab_ready", in_ready, 1);
        tick();
        chk("ab_no_done_later", done, 0);

        // asynchronous reset mid-frame
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_ser_valid", ser_valid, 0);
        chk("mr_ser_out", ser_out, 0);
        chk("mr_done", done, 0);
        chk("mr_sr_ctrl", sr_ctrl, SR_HOLD);
        chk("mr_reg", dut.sr_q, 0);
        tick();
        rst = 1'b0;
        tick();

        // back-to-back 8'h01 then 8'h80, in_valid held high
        in_data = 8'h01; in_valid = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 1) in_data = 8'h80;
            if (c == 11) in_valid = 1'b0;
            #1;
            if (c >= 1 && c <= 8) chk("b2b_w0_bit", ser_out, c == 1);
            if (c == 9) begin
                chk("b2b_done0", done, 1);
                chk("b2b_busy_ready", in_ready, 0);
            end
            if (c == 10) begin
                chk("b2b_accept2", in_ready, 1);
                chk("b2b_load2", sr_ctrl, SR_LOAD);
            end
            if (c >= 11 && c <= 18) chk("b2b_w1_bit", ser_out, c == 18);
            if (c == 19) chk("b2b_done1", done, 1);
        end

        // fill_bit=1 with 8'h00 leaves all ones
        tick();
        in_data = 8'h00; in_valid = 1'b1; fill_bit = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("fill_done", done, 1);
        chk("fill_reg", dut.sr_q, 8'hFF);
        fill_bit = 1'b0;

        // randomized traffic
        repeat (600) begin
            tick();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            ser_ready = ($urandom_range(0, 9) < 7);
            abort     = ($urandom_range(0, 39) == 0);
            fill_bit  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        abort = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
